// File: rtl/mult_seq_control.sv
// ----------------------------------------------------------------------------
// mult_seq_control
// Sequencer for a shift-and-add multiplier datapath (X flag : A accumulator :
// B multiplier register). One operation walks CLEAR, then WIDTH ADD/SHIFT
// pairs, then parks in HOLD until the start request is released. In signed
// mode the final partial product is subtracted (two's-complement sign weight).
//
// Ports
//   Clk        rising-edge clock
//   Reset      synchronous active-high reset, gates every output low
//   Execute    level start request
//   Load_Req   load operand B (honoured only in IDLE without Execute)
//   Mode_Ovr   take the mode from Signed_In instead of SIGNED_DEFAULT
//   Signed_In  mode select when Mode_Ovr is high
//   M          current LSB of the multiplier register
//   Clr_XA     clear X flag and accumulator A
//   Ld_B       load operand B
//   Add / Sub  add / subtract S into A (never both)
//   Shift_En   arithmetic right shift of X:A:B
//   Busy       high in CLEAR, ADD and SHIFT
//   Done       high in HOLD
//   Bit_Cnt    number of completed shifts (0..WIDTH)
// ----------------------------------------------------------------------------
module mult_seq_control #(
  parameter int WIDTH          = 8,
  parameter bit SIGNED_DEFAULT = 1'b1
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         Execute,
  input  logic                         Load_Req,
  input  logic                         Mode_Ovr,
  input  logic                         Signed_In,
  input  logic                         M,
  output logic                         Clr_XA,
  output logic                         Ld_B,
  output logic                         Add,
  output logic                         Sub,
  output logic                         Shift_En,
  output logic                         Busy,
  output logic                         Done,
  output logic [$clog2(WIDTH+1)-1:0]   Bit_Cnt
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ADD   = 3'd2,
    S_SHIFT = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_nxt_s;
  logic            mode_r;      // latched mode: 1 = two's-complement
  logic            mode_nxt_s;

  // State, shift counter and latched mode registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= S_IDLE;
      cnt_r   <= CNT_ZERO;
      mode_r  <= SIGNED_DEFAULT;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      mode_r  <= mode_nxt_s;
    end
  end

  // Next-state, next-count and mode-latch logic.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    mode_nxt_s  = mode_r;
    case (state_r)
      S_IDLE: begin
        if (Execute) begin
          state_nxt_s = S_CLEAR;
          cnt_nxt_s   = CNT_ZERO;
          mode_nxt_s  = Mode_Ovr ? Signed_In : SIGNED_DEFAULT;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_CLEAR: begin
        state_nxt_s = S_ADD;
        cnt_nxt_s   = CNT_ZERO;
      end
      S_ADD: begin
        state_nxt_s = S_SHIFT;
      end
      S_SHIFT: begin
        // ">=" rather than "==" so a corrupted count saturates at WIDTH
        // instead of running past it.
        if (cnt_r >= CNT_LAST) begin
          state_nxt_s = S_HOLD;
          cnt_nxt_s   = CNT_FULL;
        end else begin
          state_nxt_s = S_ADD;
          cnt_nxt_s   = cnt_r + CNT_ONE;
        end
      end
      S_HOLD: begin
        cnt_nxt_s = CNT_FULL;
        // A held Execute keeps us here so it cannot start a second run.
        if (!Execute) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_HOLD;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
        cnt_nxt_s   = CNT_ZERO;
      end
    endcase
  end

  // Output decode: Moore strobes from the state, Ld_B/Add/Sub also use inputs;
  // everything is forced low while Reset is high.
  always_comb begin
    Clr_XA   = 1'b0;
    Ld_B     = 1'b0;
    Add      = 1'b0;
    Sub      = 1'b0;
    Shift_En = 1'b0;
    Busy     = 1'b0;
    Done     = 1'b0;
    Bit_Cnt  = CNT_ZERO;
    if (Reset) begin
      Bit_Cnt = CNT_ZERO;
    end else begin
      Bit_Cnt = cnt_r;
      case (state_r)
        S_IDLE: begin
          Ld_B = Load_Req & ~Execute;
        end
        S_CLEAR: begin
          Clr_XA = 1'b1;
          Busy   = 1'b1;
        end
        S_ADD: begin
          Busy = 1'b1;
          if (M) begin
            // Sign bit of a two's-complement multiplier has negative weight.
            if ((cnt_r == CNT_LAST) && mode_r) begin
              Sub = 1'b1;
            end else begin
              Add = 1'b1;
            end
          end else begin
            Add = 1'b0;
            Sub = 1'b0;
          end
        end
        S_SHIFT: begin
          Shift_En = 1'b1;
          Busy     = 1'b1;
        end
        S_HOLD: begin
          Done = 1'b1;
        end
        default: begin
          Bit_Cnt = cnt_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_control.sv
// Scoreboard bench for mult_seq_control: three builds (WIDTH 8, 16, 2).
// Stimulus pushes expected strobe events; the monitor pops one per observed
// strobe / Done edge and compares instance, kind, Bit_Cnt and cycle offset
// from the last Clr_XA.
module tb_mult_seq_control;

  localparam int EV_CLR = 0;
  localparam int EV_LDB = 1;
  localparam int EV_ADD = 2;
  localparam int EV_SUB = 3;
  localparam int EV_SHF = 4;
  localparam int EV_DR  = 5;  // Done rising
  localparam int EV_DF  = 6;  // Done falling

  typedef struct {
    int inst;
    int kind;
    int cnt;   // -1 = don't care
    int off;   // -1 = don't care
  } ev_t;

  ev_t q[$];
  int  n_vec = 0;
  int  n_bad = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ldrq = 1'b0;
  logic mode_ovr = 1'b0;
  logic sig_in = 1'b0;
  logic [2:0] exe = 3'b000;
  logic [2:0] m_s, clr, ldb, add, sub, shf, busy, done;
  logic [3:0]  bc8;
  logic [4:0]  bc16;
  logic [1:0]  bc2;
  logic [7:0]  mb8  = 8'h00;
  logic [15:0] mb16 = 16'h0000;
  logic [1:0]  mb2  = 2'b00;
  logic [4:0]  bcv [3];

  always #5 clk = ~clk;

  assign bcv[0] = {1'b0, bc8};
  assign bcv[1] = bc16;
  assign bcv[2] = {3'b000, bc2};

  // Multiplier LSB as the datapath would present it for the current bit.
  assign m_s[0] = (bc8 < 4'd8)   ? mb8[bc8[2:0]]   : 1'b0;
  assign m_s[1] = (bc16 < 5'd16) ? mb16[bc16[3:0]] : 1'b0;
  assign m_s[2] = (bc2 < 2'd2)   ? mb2[bc2[0]]     : 1'b0;

  mult_seq_control #(.WIDTH(8)) u_w8 (
    .Clk(clk), .Reset(rst), .Execute(exe[0]), .Load_Req(ldrq),
    .Mode_Ovr(mode_ovr), .Signed_In(sig_in), .M(m_s[0]),
    .Clr_XA(clr[0]), .Ld_B(ldb[0]), .Add(add[0]), .Sub(sub[0]),
    .Shift_En(shf[0]), .Busy(busy[0]), .Done(done[0]), .Bit_Cnt(bc8));

  mult_seq_control #(.WIDTH(16)) u_w16 (
    .Clk(clk), .Reset(rst), .Execute(exe[1]), .Load_Req(1'b0),
    .Mode_Ovr(mode_ovr), .Signed_In(sig_in), .M(m_s[1]),
    .Clr_XA(clr[1]), .Ld_B(ldb[1]), .Add(add[1]), .Sub(sub[1]),
    .Shift_En(shf[1]), .Busy(busy[1]), .Done(done[1]), .Bit_Cnt(bc16));

  mult_seq_control #(.WIDTH(2)) u_w2 (
    .Clk(clk), .Reset(rst), .Execute(exe[2]), .Load_Req(1'b0),
    .Mode_Ovr(mode_ovr), .Signed_In(sig_in), .M(m_s[2]),
    .Clr_XA(clr[2]), .Ld_B(ldb[2]), .Add(add[2]), .Sub(sub[2]),
    .Shift_En(shf[2]), .Busy(busy[2]), .Done(done[2]), .Bit_Cnt(bc2));

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int i, input int k, input int c, input int o);
    ev_t e;
    e.inst = i; e.kind = k; e.cnt = c; e.off = o;
    q.push_back(e);
  endtask

  // Expected events of one full operation: CLEAR at offset 0, bit k's ADD
  // cycle at 1+2k, its SHIFT at 2+2k, HOLD entry at 1+2W.
  task automatic push_op(input int i, input int w, input logic [15:0] mb,
                         input bit sgn, input int fall_off);
    push(i, EV_CLR, 0, 0);
    for (int k = 0; k < w; k++) begin
      if (mb[k]) push(i, (k == w - 1 && sgn) ? EV_SUB : EV_ADD, k, 1 + 2 * k);
      push(i, EV_SHF, k, 2 + 2 * k);
    end
    push(i, EV_DR, w, 1 + 2 * w);
    if (fall_off >= 0) push(i, EV_DF, -1, fall_off);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle Execute pulse from IDLE; returns in the CLEAR cycle.
  task automatic pulse(input int i);
    exe[i] = 1'b1;
    step(1);
    exe[i] = 1'b0;
  endtask

  int  off [3] = '{0, 0, 0};
  logic [2:0] done_prev = 3'b000;

  // Monitor: turn each observed strobe / Done edge into an event and score it.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      int cur, kind, nstb;
      ev_t e;
      cur  = clr[i] ? 0 : off[i] + 1;
      nstb = int'(clr[i]) + int'(ldb[i]) + int'(add[i]) + int'(sub[i]) + int'(shf[i]);
      kind = -1;
      if (clr[i])                       kind = EV_CLR;
      else if (ldb[i])                  kind = EV_LDB;
      else if (add[i])                  kind = EV_ADD;
      else if (sub[i])                  kind = EV_SUB;
      else if (shf[i])                  kind = EV_SHF;
      else if (done[i] && !done_prev[i]) kind = EV_DR;
      else if (!done[i] && done_prev[i]) kind = EV_DF;
      if (nstb > 1) chk("one_strobe", nstb, 1);
      if (kind >= 0) begin
        n_vec++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_event: inst=%0d kind=%0d cnt=%0d off=%0d, expected none",
                   i, kind, bcv[i], cur);
        end else begin
          e = q.pop_front();
          if (e.inst != i || e.kind != kind ||
              (e.cnt >= 0 && e.cnt != int'(bcv[i])) ||
              (e.off >= 0 && e.off != cur)) begin
            n_bad++;
            $display("FAIL event: got inst=%0d kind=%0d cnt=%0d off=%0d, expected inst=%0d kind=%0d cnt=%0d off=%0d",
                     i, kind, bcv[i], cur, e.inst, e.kind, e.cnt, e.off);
          end
        end
      end
      off[i]       <= cur;
      done_prev[i] <= done[i];
    end
  end

  initial begin
    // Reset: outputs low even with Load_Req high, then registered reset state.
    ldrq = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_ldb", ldb[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_done", done[0], 0);
    chk("rst_clr", clr[0], 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ldrq = 1'b0;
    chk("post_rst_cnt", bc8, 0);
    chk("post_rst_busy", busy[0], 0);
    chk("post_rst_done", done[0], 0);
    step(2);

    // Load B while idle.
    push(0, EV_LDB, -1, -1);
    ldrq = 1'b1;
    step(1);
    ldrq = 1'b0;
    step(2);

    // Signed, M = 1,0,1,1,0,0,0,1; Load_Req and mode inputs wiggled while busy.
    mb8 = 8'h8D;
    push_op(0, 8, 16'h008D, 1'b1, 18);
    pulse(0);
    for (int c = 0; c < 20; c++) begin
      ldrq     = (c >= 2 && c <= 12);
      mode_ovr = (c >= 2 && c <= 12);
      sig_in   = 1'b0;
      step(1);
    end
    ldrq = 1'b0; mode_ovr = 1'b0;
    step(2);

    // Override to unsigned, all ones: final bit adds.
    mb8 = 8'hFF;
    mode_ovr = 1'b1; sig_in = 1'b0;
    push_op(0, 8, 16'h00FF, 1'b0, 18);
    pulse(0);
    sig_in = 1'b1;
    step(20);
    mode_ovr = 1'b0; sig_in = 1'b0;
    step(2);

    // Execute and Load_Req together: Execute wins, no Ld_B.
    mb8 = 8'h01;
    push_op(0, 8, 16'h0001, 1'b1, 18);
    ldrq = 1'b1;
    pulse(0);
    ldrq = 1'b0;
    step(20);

    // Execute held 40 cycles: one run, Done until release, IDLE next cycle.
    mb8 = 8'h80;
    push_op(0, 8, 16'h0080, 1'b1, 40);
    exe[0] = 1'b1;
    step(40);
    exe[0] = 1'b0;
    step(4);

    // Reset during the SHIFT of bit 3: nothing further issued.
    mb8 = 8'hFF;
    push(0, EV_CLR, 0, 0);
    for (int k = 0; k < 4; k++) begin
      push(0, EV_ADD, k, 1 + 2 * k);
      if (k < 3) push(0, EV_SHF, k, 2 + 2 * k);
    end
    pulse(0);
    step(8);
    chk("mid_shift_cnt", bc8, 3);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("mid_rst_cnt", bc8, 0);
    chk("mid_rst_busy", busy[0], 0);
    step(20);
    chk("mid_rst_idle_busy", busy[0], 0);

    // WIDTH=16 signed: Sub at Bit_Cnt=15, HOLD at offset 33.
    mb16 = 16'h8001;
    push_op(1, 16, 16'h8001, 1'b1, 34);
    pulse(1);
    step(36);

    // WIDTH=2 signed: Sub at Bit_Cnt=1, HOLD at offset 5.
    mb2 = 2'b11;
    push_op(2, 2, 16'h0003, 1'b1, 6);
    pulse(2);
    step(8);

    // WIDTH=2 unsigned via override: final bit adds.
    mb2 = 2'b10;
    mode_ovr = 1'b1; sig_in = 1'b0;
    push_op(2, 2, 16'h0002, 1'b0, 6);
    pulse(2);
    mode_ovr = 1'b0;
    step(8);

    step(3);
    chk("events_left", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
